// File: rtl/data_mem_responder.sv
// Load/store responder with configurable wait states in front of an internal word RAM.
// Optional alignment errors are enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAT_LOAD   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        accept;

   logic [31:0] ram [DEPTH];
   logic [31:0] word;
   logic [31:0] load_data;
   logic [31:0] merged;
   logic [31:0] wdata_rep;
   logic [3:0]  be;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        misalign;
   logic        access_err;

   // Handshake: a request is taken on a rising edge where req_valid and req_ready are both high.
   assign req_ready  = (state == IDLE) & ~reset;
   assign resp_valid = (state == RESP) & ~reset;
   assign accept     = req_valid & req_ready;
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY > 0) begin
                  state_nxt = WAIT;
                  cnt_nxt   = LAT_LOAD;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = ((f3_q[1:0] == 2'b01) & addr_q[0]) |
                     ((f3_q[1:0] == 2'b10) & (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign access_err = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11) | (we_q & f3_q[2]) |
                       (addr_q >= ADDR_LIMIT) | misalign;

   assign word = ram[addr_q[AW+1:2]];

   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_q[1] ? word[31:16] : word[15:0];
      case (f3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_data = word;
         3'b100:  load_data = {24'd0, byte_sel};
         3'b101:  load_data = {16'd0, half_sel};
         default: load_data = 32'd0;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick what lands.
   always_comb begin
      case (f3_q[1:0])
         2'b00: begin
            be        = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be        = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata_q;
         end
      endcase
      merged = word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if ((state == RESP) && !reset && we_q && !access_err)
         ram[addr_q[AW+1:2]] <= merged;
   end

   assign resp_rdata = (resp_valid & ~we_q & ~access_err) ? load_data : 32'd0;
   assign resp_err   = resp_valid & access_err;

endmodule
